// File: rtl/frame_filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_filter_sequencer
// Brief    : Per-frame controller for the median-filter / histogram datapath.
//            Sequences init/start, then scans the x/y histograms for peaks.
// Revision : 1.0 - initial release
// ============================================================================
module frame_filter_sequencer #(
    parameter int unsigned NUM_BINS       = 256,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int unsigned INIT_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_req,
    input  logic [12:0] threshold_cfg,
    output logic        init,
    output logic        start,
    output logic [12:0] threshold,
    input  logic        wake_up,
    input  logic        full_image_done,
    output logic        read_histogram,
    input  logic [7:0]  x_hist_in,
    input  logic        x_valid,
    input  logic [7:0]  y_hist_in,
    input  logic        y_valid,
    output logic        busy,
    output logic        result_valid,
    output logic [7:0]  x_peak_idx,
    output logic [7:0]  y_peak_idx,
    output logic [7:0]  x_peak_cnt,
    output logic [7:0]  y_peak_cnt,
    output logic        timeout_err,
    output logic        req_dropped
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_WAKE   = 3'd2,
        S_START  = 3'd3,
        S_FILTER = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam int unsigned        c_init_w    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_CYCLES - 1);
    // Nine-bit limit so that a 256-bin scan terminates without wrapping.
    localparam logic [8:0]         c_bin_limit = 9'(NUM_BINS);
    localparam logic [23:0]        c_wd_last   = TIMEOUT_CYCLES - 24'd1;

    state_t              r_state;
    logic [c_init_w-1:0] r_init_cnt;
    logic [23:0]         r_wd_cnt;
    logic [8:0]          r_x_bin_cnt;
    logic [8:0]          r_y_bin_cnt;

    logic       w_x_take;
    logic       w_y_take;
    logic [8:0] w_x_cnt_nxt;
    logic [8:0] w_y_cnt_nxt;
    logic       w_read_done;
    logic       w_wd_expired;
    logic       w_abort;

    always_comb begin
        w_x_take     = (r_state == S_READ) && x_valid && (r_x_bin_cnt < c_bin_limit);
        w_y_take     = (r_state == S_READ) && y_valid && (r_y_bin_cnt < c_bin_limit);
        w_x_cnt_nxt  = r_x_bin_cnt + {8'd0, w_x_take};
        w_y_cnt_nxt  = r_y_bin_cnt + {8'd0, w_y_take};
        // Look at the post-sample counts so DONE follows the last sample directly.
        w_read_done  = (w_x_cnt_nxt == c_bin_limit) && (w_y_cnt_nxt == c_bin_limit);
        w_wd_expired = (r_wd_cnt == c_wd_last);
        w_abort      = 1'b0;
        if (w_wd_expired) begin
            case (r_state)
                S_WAKE:   w_abort = !wake_up;
                S_FILTER: w_abort = !full_image_done;
                S_READ:   w_abort = !w_read_done;
                default:  w_abort = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_init_cnt     <= '0;
            r_wd_cnt       <= 24'd0;
            r_x_bin_cnt    <= 9'd0;
            r_y_bin_cnt    <= 9'd0;
            init           <= 1'b0;
            start          <= 1'b0;
            threshold      <= 13'd0;
            read_histogram <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            x_peak_idx     <= 8'd0;
            y_peak_idx     <= 8'd0;
            x_peak_cnt     <= 8'd0;
            y_peak_cnt     <= 8'd0;
            timeout_err    <= 1'b0;
            req_dropped    <= 1'b0;
        end else begin
            start        <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            req_dropped  <= frame_req && (r_state != S_IDLE);

            // Strict compare keeps the lowest index on ties.
            if (w_x_take && (x_hist_in > x_peak_cnt)) begin
                x_peak_cnt <= x_hist_in;
                x_peak_idx <= r_x_bin_cnt[7:0];
            end
            if (w_y_take && (y_hist_in > y_peak_cnt)) begin
                y_peak_cnt <= y_hist_in;
                y_peak_idx <= r_y_bin_cnt[7:0];
            end
            r_x_bin_cnt <= w_x_cnt_nxt;
            r_y_bin_cnt <= w_y_cnt_nxt;

            case (r_state)
                S_IDLE: begin
                    if (frame_req) begin
                        threshold   <= threshold_cfg;
                        x_peak_idx  <= 8'd0;
                        y_peak_idx  <= 8'd0;
                        x_peak_cnt  <= 8'd0;
                        y_peak_cnt  <= 8'd0;
                        r_x_bin_cnt <= 9'd0;
                        r_y_bin_cnt <= 9'd0;
                        r_init_cnt  <= c_init_last;
                        init        <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (r_init_cnt == '0) begin
                        init     <= 1'b0;
                        r_wd_cnt <= 24'd0;
                        r_state  <= S_WAKE;
                    end else begin
                        r_init_cnt <= r_init_cnt - 1'b1;
                    end
                end
                S_WAKE: begin
                    if (wake_up) begin
                        start   <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 24'd1;
                    end
                end
                S_START: begin
                    r_wd_cnt <= 24'd0;
                    r_state  <= S_FILTER;
                end
                S_FILTER: begin
                    if (full_image_done) begin
                        read_histogram <= 1'b1;
                        r_wd_cnt       <= 24'd0;
                        r_state        <= S_READ;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 24'd1;
                    end
                end
                S_READ: begin
                    if (w_read_done) begin
                        read_histogram <= 1'b0;
                        result_valid   <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 24'd1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    init           <= 1'b0;
                    read_histogram <= 1'b0;
                    busy           <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase

            // Watchdog abort overrides the phase logic; peaks keep partial values.
            if (w_abort) begin
                timeout_err    <= 1'b1;
                init           <= 1'b0;
                start          <= 1'b0;
                read_histogram <= 1'b0;
                busy           <= 1'b0;
                r_state        <= S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_filter_sequencer
// Brief    : Self-checking bench: table vectors, corner sequences and random
//            frames against a histogram-peak reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_filter_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        frame_req;
    logic [12:0] threshold_cfg;
    logic        wake_up;
    logic        full_image_done;
    logic [7:0]  x_hist_in;
    logic        x_valid;
    logic [7:0]  y_hist_in;
    logic        y_valid;
    logic        sel;
    logic        req_a;
    logic        req_b;

    assign req_a = frame_req & ~sel;
    assign req_b = frame_req & sel;

    logic        a_init, a_start, a_read, a_busy, a_rv, a_to, a_rd;
    logic [12:0] a_thr;
    logic [7:0]  a_xpi, a_ypi, a_xpc, a_ypc;
    logic        b_init, b_start, b_read, b_busy, b_rv, b_to, b_rd;
    logic [12:0] b_thr;
    logic [7:0]  b_xpi, b_ypi, b_xpc, b_ypc;

    frame_filter_sequencer #(.NUM_BINS(4), .TIMEOUT_CYCLES(24'd16), .INIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .frame_req(req_a), .threshold_cfg(threshold_cfg),
        .init(a_init), .start(a_start), .threshold(a_thr), .wake_up(wake_up),
        .full_image_done(full_image_done), .read_histogram(a_read),
        .x_hist_in(x_hist_in), .x_valid(x_valid), .y_hist_in(y_hist_in), .y_valid(y_valid),
        .busy(a_busy), .result_valid(a_rv), .x_peak_idx(a_xpi), .y_peak_idx(a_ypi),
        .x_peak_cnt(a_xpc), .y_peak_cnt(a_ypc), .timeout_err(a_to), .req_dropped(a_rd)
    );

    frame_filter_sequencer #(.NUM_BINS(256), .TIMEOUT_CYCLES(24'd2000), .INIT_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .frame_req(req_b), .threshold_cfg(threshold_cfg),
        .init(b_init), .start(b_start), .threshold(b_thr), .wake_up(wake_up),
        .full_image_done(full_image_done), .read_histogram(b_read),
        .x_hist_in(x_hist_in), .x_valid(x_valid), .y_hist_in(y_hist_in), .y_valid(y_valid),
        .busy(b_busy), .result_valid(b_rv), .x_peak_idx(b_xpi), .y_peak_idx(b_ypi),
        .x_peak_cnt(b_xpc), .y_peak_cnt(b_ypc), .timeout_err(b_to), .req_dropped(b_rd)
    );

    logic        m_init, m_start, m_read, m_busy, m_rv, m_to, m_rd;
    logic [12:0] m_thr;
    logic [7:0]  m_xpi, m_ypi, m_xpc, m_ypc;
    logic [51:0] m_all;

    assign m_init  = sel ? b_init  : a_init;
    assign m_start = sel ? b_start : a_start;
    assign m_read  = sel ? b_read  : a_read;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_rv    = sel ? b_rv    : a_rv;
    assign m_to    = sel ? b_to    : a_to;
    assign m_rd    = sel ? b_rd    : a_rd;
    assign m_thr   = sel ? b_thr   : a_thr;
    assign m_xpi   = sel ? b_xpi   : a_xpi;
    assign m_ypi   = sel ? b_ypi   : a_ypi;
    assign m_xpc   = sel ? b_xpc   : a_xpc;
    assign m_ypc   = sel ? b_ypc   : a_ypc;
    assign m_all   = {m_init, m_start, m_thr, m_read, m_busy, m_rv,
                      m_xpi, m_ypi, m_xpc, m_ypc, m_to, m_rd};

    int         total;
    int         bad;
    int         nb;
    int         ic;
    logic [7:0] xv [256];
    logic [7:0] yv [256];

    typedef struct {
        logic [12:0] thr;
        logic [31:0] xs;
        logic [31:0] ys;
        int          xoff;
        int          yoff;
        int          wake;
        int          dly;
        bit          drop;
        bit          junk;
        logic [31:0] expv;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Peak = largest value; its index is the first bin holding that value.
    function automatic logic [15:0] model_peak(input bit use_y);
        int mx;
        int idx;
        mx = 0;
        for (int i = 0; i < nb; i++) begin
            int v;
            v = use_y ? int'(yv[i]) : int'(xv[i]);
            if (v > mx) mx = v;
        end
        idx = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            if ((use_y ? int'(yv[i]) : int'(xv[i])) == mx) idx = i;
        end
        return {8'(idx), 8'(mx)};
    endfunction

    task automatic request(input logic [12:0] thr);
        int n;
        frame_req = 1'b1;
        threshold_cfg = thr;
        tick();
        frame_req = 1'b0;
        threshold_cfg = 13'($urandom);
        chk("accept", {m_init, m_busy, m_thr, m_xpi, m_xpc, m_ypi, m_ypc},
            {1'b1, 1'b1, thr, 32'd0});
        n = 0;
        while (m_init === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk("init_width", 64'(n), 64'(ic));
    endtask

    task automatic go_to_read(input logic [12:0] thr, input int wake_dly,
                              input int done_dly, input bit drop);
        request(thr);
        for (int i = 0; i < wake_dly; i++) tick();
        wake_up = 1'b1;
        tick();
        wake_up = 1'b0;
        chk("start_pulse", {m_start, m_busy}, 2'b11);
        tick();
        chk("start_width", {m_start, m_busy}, 2'b01);
        for (int i = 0; i < done_dly; i++) begin
            if (drop && i == 0) begin
                frame_req = 1'b1;
                threshold_cfg = ~thr;
            end
            tick();
            frame_req = 1'b0;
            if (drop && i == 0) chk("req_dropped", {m_rd, m_thr}, {1'b1, thr});
            if (drop && i == 1) chk("req_dropped_width", {m_rd, m_busy}, 2'b01);
        end
        full_image_done = 1'b1;
        tick();
        full_image_done = 1'b0;
        chk("read_enter", {m_read, m_rv}, 2'b10);
    endtask

    task automatic stream(input int xoff, input int yoff, input int maxgap, input bit junk);
        int xs, ys, xw, yw, c;
        bit fin;
        xs = 0; ys = 0; xw = xoff; yw = yoff; c = 0; fin = 1'b0;
        while (!fin && c < 4000) begin
            if (xs < nb) begin
                if (xw == 0) begin
                    x_valid = 1'b1; x_hist_in = xv[xs]; xs++;
                    xw = int'($urandom_range(maxgap, 0));
                end else begin
                    x_valid = 1'b0; x_hist_in = 8'($urandom); xw--;
                end
            end else begin
                x_valid = junk && ($urandom_range(1, 0) == 1);
                x_hist_in = 8'hFF;
            end
            if (ys < nb) begin
                if (yw == 0) begin
                    y_valid = 1'b1; y_hist_in = yv[ys]; ys++;
                    yw = int'($urandom_range(maxgap, 0));
                end else begin
                    y_valid = 1'b0; y_hist_in = 8'($urandom); yw--;
                end
            end else begin
                y_valid = junk && ($urandom_range(1, 0) == 1);
                y_hist_in = 8'hFF;
            end
            fin = (xs == nb) && (ys == nb);
            tick();
            if (fin) chk("result_strobe", {m_rv, m_read, m_busy}, 3'b101);
            else     chk("read_hold", {m_rv, m_read, m_to}, 3'b010);
            c++;
        end
        x_valid = 1'b0;
        y_valid = 1'b0;
        if (!fin) chk("stream_bound", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input logic [12:0] thr, input int wake_dly, input int done_dly,
                             input bit drop, input int xoff, input int yoff, input int maxgap,
                             input bit junk, input logic [31:0] expv);
        go_to_read(thr, wake_dly, done_dly, drop);
        stream(xoff, yoff, maxgap, junk);
        chk("peaks", {m_xpi, m_xpc, m_ypi, m_ypc}, expv);
        chk("thr_hold", m_thr, thr);
        tick();
        chk("post_done", {m_rv, m_busy, m_read, m_to, m_xpi, m_xpc, m_ypi, m_ypc},
            {4'b0000, expv});
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        bit seen;
        logic [31:0] e;

        tbl[0] = '{13'd100,  {8'd2, 8'd9, 8'd9, 8'd3},     {8'd1, 8'd5, 8'd0, 8'd0},
                   0, 0, 1, 3, 1'b0, 1'b0, {8'd1, 8'd9, 8'd2, 8'd5}};
        tbl[1] = '{13'd7,    {8'd4, 8'd3, 8'd2, 8'd1},     {8'd1, 8'd2, 8'd3, 8'd4},
                   0, 6, 0, 2, 1'b0, 1'b1, {8'd3, 8'd4, 8'd0, 8'd4}};
        tbl[2] = '{13'h1FFF, {8'd7, 8'd0, 8'd0, 8'd0},     {8'd8, 8'd8, 8'd8, 8'd8},
                   5, 0, 4, 3, 1'b1, 1'b1, {8'd3, 8'd7, 8'd0, 8'd8}};
        tbl[3] = '{13'd0,    {8'd5, 8'd5, 8'd5, 8'd5},     {8'd0, 8'd0, 8'd0, 8'd0},
                   1, 2, 2, 2, 1'b0, 1'b0, {8'd0, 8'd5, 8'd0, 8'd0}};
        tbl[4] = '{13'd4096, {8'd255, 8'd0, 8'd255, 8'd254}, {8'd2, 8'd0, 8'd0, 8'd1},
                   0, 1, 3, 5, 1'b0, 1'b1, {8'd1, 8'd255, 8'd3, 8'd2}};
        tbl[5] = '{13'd1,    {8'd1, 8'd0, 8'd0, 8'd0},     {8'd0, 8'd3, 8'd3, 8'd0},
                   2, 0, 0, 2, 1'b0, 1'b0, {8'd3, 8'd1, 8'd1, 8'd3}};

        total = 0; bad = 0; sel = 1'b0; nb = 4; ic = 2;
        reset = 1'b1; frame_req = 1'b0; threshold_cfg = 13'h0AA; wake_up = 1'b0;
        full_image_done = 1'b0; x_hist_in = 8'd0; x_valid = 1'b0; y_hist_in = 8'd0; y_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin xv[i] = 8'd0; yv[i] = 8'd0; end
        repeat (3) tick();
        chk("reset_a", m_all, 52'd0);
        sel = 1'b1; #1;
        chk("reset_b", m_all, 52'd0);
        sel = 1'b0; #1;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                xv[j] = tbl[i].xs[8*j +: 8];
                yv[j] = tbl[i].ys[8*j +: 8];
            end
            run_frame(tbl[i].thr, tbl[i].wake, tbl[i].dly, tbl[i].drop, tbl[i].xoff,
                      tbl[i].yoff, 0, tbl[i].junk, tbl[i].expv);
        end

        // wake_up never arrives: watchdog fires 16 cycles after WAKE entry
        request(13'd321);
        k = 0; seen = 1'b0;
        while (m_to !== 1'b1 && k < 40) begin
            tick();
            k++;
            if (m_start === 1'b1) seen = 1'b1;
        end
        chk("wake_timeout_cycles", 64'(k), 64'd16);
        chk("wake_abort_state", {seen, m_start, m_busy, m_init, m_rv}, 5'b0);
        tick();
        chk("wake_abort_strobe", {m_to, m_busy}, 2'b00);

        // READ stalls after partial samples: abort keeps partial peaks
        go_to_read(13'd55, 1, 2, 1'b0);
        k = 0;
        while (m_to !== 1'b1 && k < 40) begin
            x_valid = (k < 2); x_hist_in = (k == 0) ? 8'd0 : 8'd50;
            y_valid = (k == 0); y_hist_in = 8'd7;
            tick();
            k++;
        end
        x_valid = 1'b0; y_valid = 1'b0;
        chk("read_timeout_cycles", 64'(k), 64'd16);
        chk("read_abort_partial", {m_xpi, m_xpc, m_ypi, m_ypc, m_read, m_busy, m_rv},
            {8'd1, 8'd50, 8'd0, 8'd7, 3'b000});
        tick();
        chk("read_abort_strobe", {m_to, m_busy, m_rv}, 3'b000);

        // Reset during READ after two samples
        go_to_read(13'd999, 0, 2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            x_valid = 1'b1; x_hist_in = 8'(200 + 10 * i);
            y_valid = 1'b1; y_hist_in = 8'(220 + 10 * i);
            tick();
        end
        x_valid = 1'b0; y_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid", m_all, 52'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_rv !== 1'b0 || m_to !== 1'b0 || m_busy !== 1'b0) seen = 1'b1;
        end
        chk("reset_quiet", {63'd0, seen}, 64'd0);
        for (int j = 0; j < 4; j++) begin
            xv[j] = tbl[5].xs[8*j +: 8];
            yv[j] = tbl[5].ys[8*j +: 8];
        end
        run_frame(13'd42, 1, 2, 1'b0, 0, 0, 0, 1'b0, tbl[5].expv);

        // Random frames on the 4-bin instance
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 4; j++) begin
                xv[j] = ($urandom_range(9, 0) == 0) ? 8'd255 : 8'($urandom_range(15, 0));
                yv[j] = 8'($urandom_range(15, 0));
            end
            e = {model_peak(1'b0), model_peak(1'b1)};
            run_frame(13'($urandom), int'($urandom_range(8, 0)), int'($urandom_range(8, 2)),
                      1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)), 1, 1'b1, e);
        end

        // 256-bin instance: all-zero histograms, then a peak in the last bin
        sel = 1'b1; #1;
        nb = 256; ic = 3;
        for (int i = 0; i < 256; i++) begin xv[i] = 8'd0; yv[i] = 8'd0; end
        run_frame(13'd77, 2, 4, 1'b0, 0, 5, 0, 1'b1, 32'd0);
        for (int i = 0; i < 256; i++) begin
            xv[i] = 8'($urandom_range(200, 0));
            yv[i] = 8'($urandom);
        end
        xv[255] = 8'd255;
        e = {model_peak(1'b0), model_peak(1'b1)};
        run_frame(13'd5000, 3, 2, 1'b1, 0, 2, 0, 1'b1, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
